// File: rtl/async_fifo_stat_pkg.sv
// Shared helpers for the dual-clock statistics FIFO: Gray/binary conversion,
// pointer width derivation and the Gray pattern used for the full compare.
package async_fifo_pkg;

    // Widest pointer the helpers handle; callers zero-extend and truncate.
    localparam int GRAY_W = 32;

    // Pointer width: one extra wrap bit above the RAM address.
    function automatic int ptr_width(input int addr_width);
        return addr_width + 1;
    endfunction

    // Binary to reflected Gray code.
    function automatic logic [GRAY_W-1:0] bin2gray(input logic [GRAY_W-1:0] bin);
        return bin ^ {1'b0, bin[GRAY_W-1:1]};
    endfunction

    // Reflected Gray code to binary.
    function automatic logic [GRAY_W-1:0] gray2bin(input logic [GRAY_W-1:0] gray);
        logic [GRAY_W-1:0] bin;
        bin[GRAY_W-1] = gray[GRAY_W-1];
        for (int i = GRAY_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

    // Mask with the two MSBs of a pw-bit Gray pointer set. A write pointer that
    // equals the read pointer with these bits inverted is exactly DEPTH ahead.
    function automatic logic [GRAY_W-1:0] full_gray_mask(input int pw);
        logic [GRAY_W-1:0] mask;
        mask         = {GRAY_W{1'b0}};
        mask[pw - 1] = 1'b1;
        mask[pw - 2] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/async_fifo_stat_cdc_sync_bus.sv
// Multi-flop synchroniser for a Gray-coded pointer bus. Only one bit of the
// input changes per source clock, so sampling the whole bus is safe.
module cdc_sync_bus #(
    parameter int WIDTH       = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] sync_r [SYNC_STAGES];

    // Shift the incoming pointer through the destination-domain flop chain.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            sync_r[0] <= d;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
        end
    end

    assign q = sync_r[SYNC_STAGES-1];

endmodule

// File: rtl/async_fifo_stat.sv
// Dual-clock FIFO with fill levels, almost-full/empty thresholds and sticky
// overflow/underflow flags. Pointers cross domains only as registered Gray
// codes through cdc_sync_bus. All status outputs are registered.
// Build option: define ASYNC_FIFO_FWFT_EN for first-word-fall-through reads;
// without it reads have one cycle of latency after rd_en.
module async_fifo_stat
    import async_fifo_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 4,
    parameter int SYNC_STAGES = 2,
    parameter int AF_LEVEL    = 12,
    parameter int AE_LEVEL    = 2
) (
    input  logic                  wr_clk,
    input  logic                  wr_rstn,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_clr_err,
    output logic                  full,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   wr_level,
    output logic                  wr_overflow,
    input  logic                  rd_clk,
    input  logic                  rd_rstn,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   rd_level,
    input  logic                  rd_clr_err,
    output logic                  rd_underflow
);

    localparam int            PW        = ptr_width(ADDR_WIDTH);
    localparam int            DEPTH     = 2 ** ADDR_WIDTH;
    localparam logic [PW-1:0] FULL_MASK = PW'(full_gray_mask(PW));
    localparam logic [PW-1:0] AF_THRESH = PW'(AF_LEVEL);
    localparam logic [PW-1:0] AE_THRESH = PW'(AE_LEVEL);

    // Storage: written on wr_clk, read into a register on rd_clk, never reset.
    logic [DATA_WIDTH-1:0] mem_r [DEPTH];

    // Write-domain state
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] wr_gray_r;
    logic          full_r;
    logic          almost_full_r;
    logic [PW-1:0] wr_level_r;
    logic          wr_overflow_r;

    // Write-domain next-state
    logic          push_s;
    logic [PW-1:0] wr_ptr_next_s;
    logic [PW-1:0] wr_gray_next_s;
    logic [PW-1:0] rd_gray_wsync_s;
    logic [PW-1:0] rd_ptr_wsync_bin_s;
    logic [PW-1:0] wr_level_next_s;
    logic          full_next_s;
    logic          wr_overflow_next_s;

    // Read-domain state
    logic [PW-1:0]         rd_ptr_r;
    logic [PW-1:0]         rd_gray_r;
    logic                  ram_empty_r;
    logic                  empty_r;
    logic                  almost_empty_r;
    logic [PW-1:0]         rd_level_r;
    logic                  rd_underflow_r;
    logic [DATA_WIDTH-1:0] rd_data_r;
    logic                  rd_valid_r;

    // Read-domain next-state
    logic          fetch_s;
    logic          rd_valid_next_s;
    logic [PW-1:0] rd_ptr_next_s;
    logic [PW-1:0] rd_gray_next_s;
    logic [PW-1:0] wr_gray_rsync_s;
    logic [PW-1:0] wr_ptr_rsync_bin_s;
    logic          ram_empty_next_s;
    logic          empty_next_s;
    logic [PW-1:0] rd_level_next_s;
    logic          rd_underflow_next_s;

    // Read pointer into the write domain
    cdc_sync_bus #(
        .WIDTH       (PW),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_rd2wr_sync (
        .clk  (wr_clk),
        .rstn (wr_rstn),
        .d    (rd_gray_r),
        .q    (rd_gray_wsync_s)
    );

    // Write pointer into the read domain
    cdc_sync_bus #(
        .WIDTH       (PW),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_wr2rd_sync (
        .clk  (rd_clk),
        .rstn (rd_rstn),
        .d    (wr_gray_r),
        .q    (wr_gray_rsync_s)
    );

    // Write side: accept push, advance pointer, derive full/level/overflow.
    always_comb begin
        push_s             = wr_en & ~full_r;
        wr_ptr_next_s      = wr_ptr_r + {{(PW-1){1'b0}}, push_s};
        wr_gray_next_s     = PW'(bin2gray(GRAY_W'(wr_ptr_next_s)));
        rd_ptr_wsync_bin_s = PW'(gray2bin(GRAY_W'(rd_gray_wsync_s)));
        wr_level_next_s    = wr_ptr_next_s - rd_ptr_wsync_bin_s;
        full_next_s        = (wr_gray_next_s == (rd_gray_wsync_s ^ FULL_MASK));
        // A fresh overflow outranks a clear in the same cycle.
        if (wr_en && full_r) begin
            wr_overflow_next_s = 1'b1;
        end else if (wr_clr_err) begin
            wr_overflow_next_s = 1'b0;
        end else begin
            wr_overflow_next_s = wr_overflow_r;
        end
    end

    // Write-domain registers
    always_ff @(posedge wr_clk or negedge wr_rstn) begin
        if (!wr_rstn) begin
            wr_ptr_r      <= {PW{1'b0}};
            wr_gray_r     <= {PW{1'b0}};
            full_r        <= 1'b0;
            almost_full_r <= 1'b0;
            wr_level_r    <= {PW{1'b0}};
            wr_overflow_r <= 1'b0;
        end else begin
            wr_ptr_r      <= wr_ptr_next_s;
            wr_gray_r     <= wr_gray_next_s;
            full_r        <= full_next_s;
            almost_full_r <= (wr_level_next_s >= AF_THRESH);
            wr_level_r    <= wr_level_next_s;
            wr_overflow_r <= wr_overflow_next_s;
        end
    end

    // RAM write port
    always_ff @(posedge wr_clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r[ADDR_WIDTH-1:0]] <= wr_data;
        end
    end

    // Read side: decide whether to fetch a word from RAM, derive empty/level/underflow.
    always_comb begin
        wr_ptr_rsync_bin_s = PW'(gray2bin(GRAY_W'(wr_gray_rsync_s)));
`ifdef ASYNC_FIFO_FWFT_EN
        // Refill the output register whenever it is free or being consumed.
        fetch_s         = ~ram_empty_r & (~rd_valid_r | rd_en);
        rd_valid_next_s = fetch_s | (rd_valid_r & ~rd_en);
`else
        fetch_s         = rd_en & ~ram_empty_r;
        rd_valid_next_s = fetch_s;
`endif
        rd_ptr_next_s    = rd_ptr_r + {{(PW-1){1'b0}}, fetch_s};
        rd_gray_next_s   = PW'(bin2gray(GRAY_W'(rd_ptr_next_s)));
        ram_empty_next_s = (rd_gray_next_s == wr_gray_rsync_s);
`ifdef ASYNC_FIFO_FWFT_EN
        // The prefetched head still belongs to the visible occupancy.
        empty_next_s    = ~rd_valid_next_s;
        rd_level_next_s = wr_ptr_rsync_bin_s - rd_ptr_next_s
                          + {{(PW-1){1'b0}}, rd_valid_next_s};
`else
        empty_next_s    = ram_empty_next_s;
        rd_level_next_s = wr_ptr_rsync_bin_s - rd_ptr_next_s;
`endif
        // A fresh underflow outranks a clear in the same cycle.
        if (rd_en && empty_r) begin
            rd_underflow_next_s = 1'b1;
        end else if (rd_clr_err) begin
            rd_underflow_next_s = 1'b0;
        end else begin
            rd_underflow_next_s = rd_underflow_r;
        end
    end

    // Read-domain registers including the registered RAM read
    always_ff @(posedge rd_clk or negedge rd_rstn) begin
        if (!rd_rstn) begin
            rd_ptr_r       <= {PW{1'b0}};
            rd_gray_r      <= {PW{1'b0}};
            ram_empty_r    <= 1'b1;
            empty_r        <= 1'b1;
            almost_empty_r <= 1'b1;
            rd_level_r     <= {PW{1'b0}};
            rd_underflow_r <= 1'b0;
            rd_data_r      <= {DATA_WIDTH{1'b0}};
            rd_valid_r     <= 1'b0;
        end else begin
            rd_ptr_r       <= rd_ptr_next_s;
            rd_gray_r      <= rd_gray_next_s;
            ram_empty_r    <= ram_empty_next_s;
            empty_r        <= empty_next_s;
            almost_empty_r <= (rd_level_next_s <= AE_THRESH);
            rd_level_r     <= rd_level_next_s;
            rd_underflow_r <= rd_underflow_next_s;
            rd_valid_r     <= rd_valid_next_s;
            if (fetch_s) begin
                rd_data_r <= mem_r[rd_ptr_r[ADDR_WIDTH-1:0]];
            end else begin
                rd_data_r <= rd_data_r;
            end
        end
    end

    assign full         = full_r;
    assign almost_full  = almost_full_r;
    assign wr_level     = wr_level_r;
    assign wr_overflow  = wr_overflow_r;
    assign rd_data      = rd_data_r;
    assign rd_valid     = rd_valid_r;
    assign empty        = empty_r;
    assign almost_empty = almost_empty_r;
    assign rd_level     = rd_level_r;
    assign rd_underflow = rd_underflow_r;

endmodule
